// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire bus master: command encodings,
// controller state encoding and standard-speed timing defaults.
package onewire_pkg;

    // Default timing values, all in microseconds except the clock rate.
    localparam int unsigned DEF_CLK_HZ    = 12_000_000;
    localparam int unsigned DEF_T_RSTL_US = 480;
    localparam int unsigned DEF_T_PDS_US  = 70;
    localparam int unsigned DEF_T_SLOT_US = 60;
    localparam int unsigned DEF_T_LOW1_US = 6;
    localparam int unsigned DEF_T_RS_US   = 15;
    localparam int unsigned DEF_T_REC_US  = 10;

    // Width of the per-phase microsecond counter; comfortably covers
    // the longest phase (reset low / recovery).
    localparam int unsigned US_CNT_W = 16;

    // Byte-level commands accepted on the command interface.
    typedef enum logic [1:0] {
        CMD_RESET    = 2'b00,
        CMD_WRITE    = 2'b01,
        CMD_READ     = 2'b10,
        CMD_READ_BIT = 2'b11
    } cmd_t;

    // Controller states; exported through the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_PDS  = 3'd2,
        ST_RST_REC  = 3'd3,
        ST_SLOT_LOW = 3'd4,
        ST_SLOT_REL = 3'd5,
        ST_SLOT_REC = 3'd6,
        ST_SPU      = 3'd7
    } state_t;

    // Convert a microsecond duration into the counter value seen on the
    // tick that completes that duration.
    function automatic logic [US_CNT_W-1:0] us_last(input int unsigned us);
        return US_CNT_W'(us - 1);
    endfunction

endpackage

// File: rtl/onewire_tick.sv
// Microsecond prescaler: emits a one-cycle tick every DIV clocks.
// A restart pulse realigns the tick so the first tick after restart
// arrives exactly DIV clocks later.
module onewire_tick #(
    parameter int unsigned DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Free-running divider, cleared by reset, restart or wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/onewire_master.sv
// 1-Wire bus master for DS18B20-class sensors. Executes one byte-level
// command at a time (bus reset, write byte, read byte, read bit) and
// generates standard-speed slot timing from a microsecond tick.
//
// Command handshake: a command is accepted on a clock edge where
// i_cmd_valid and o_cmd_ready are both high; o_cmd_ready is high only
// while idle, so commands offered while busy simply wait (no queuing).
// Completion is a single-cycle o_rsp_valid pulse, coincident with
// o_cmd_ready returning high.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned T_RSTL_US = DEF_T_RSTL_US,
    parameter int unsigned T_PDS_US  = DEF_T_PDS_US,
    parameter int unsigned T_SLOT_US = DEF_T_SLOT_US,
    parameter int unsigned T_LOW1_US = DEF_T_LOW1_US,
    parameter int unsigned T_RS_US   = DEF_T_RS_US,
    parameter int unsigned T_REC_US  = DEF_T_REC_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wdata,
    input  logic       i_spu,
    input  logic       i_spu_release,
    output logic       o_rsp_valid,
    output logic [7:0] o_rdata,
    output logic       o_presence,
    output logic       o_busy,
    input  logic       I_ONE_WIRE,
    output logic       O_ONE_WIRE,
    output logic       O_STRONG_PU,
    output logic [2:0] o_dbg_state
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;

    localparam logic [US_CNT_W-1:0] RSTL_LAST = us_last(T_RSTL_US);
    localparam logic [US_CNT_W-1:0] PDS_LAST  = us_last(T_PDS_US);
    localparam logic [US_CNT_W-1:0] SLOT_LAST = us_last(T_SLOT_US);
    localparam logic [US_CNT_W-1:0] LOW1_LAST = us_last(T_LOW1_US);
    localparam logic [US_CNT_W-1:0] RS_LAST   = us_last(T_RS_US);
    localparam logic [US_CNT_W-1:0] REC_LAST  = us_last(T_REC_US);

    state_t               state_q, state_d;
    cmd_t                 cmd_q;
    logic [7:0]           data_q;
    logic                 spu_q;
    logic [2:0]           bit_cnt_q;
    logic [US_CNT_W-1:0]  us_cnt_q;
    logic                 sync1_q, sync2_q;
    logic                 pres_q;
    logic                 ow_q;
    logic                 strong_pu_q;
    logic                 rsp_q;
    logic [7:0]           rdata_q;
    logic                 presence_q;

    logic                 tick;
    logic                 accept;
    logic                 cnt_clr;
    logic                 pres_sample;
    logic                 bit_sample;
    logic                 slot_end;
    logic                 done;
    logic                 is_read;
    logic                 last_bit;
    logic                 write_zero;
    logic [US_CNT_W-1:0]  low_last;
    logic                 drive_low_d;

    assign accept     = i_cmd_valid && (state_q == ST_IDLE);
    assign is_read    = (cmd_q == CMD_READ) || (cmd_q == CMD_READ_BIT);
    assign last_bit   = (cmd_q == CMD_READ_BIT) || (bit_cnt_q == 3'd7);
    // A write-0 holds the line low for the whole slot; everything else
    // (write-1 and reads) uses the short initiation pulse.
    assign write_zero = (cmd_q == CMD_WRITE) && !data_q[0];
    assign low_last   = write_zero ? SLOT_LAST : LOW1_LAST;

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rsp_valid = rsp_q;
    assign o_rdata     = rdata_q;
    assign o_presence  = presence_q;
    assign O_ONE_WIRE  = ow_q;
    assign O_STRONG_PU = strong_pu_q;
    assign o_dbg_state = state_q;

    onewire_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    // Two-flop synchroniser for the asynchronous bus level; idles high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= I_ONE_WIRE;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes. The microsecond
    // counter runs across RST_PDS/RST_REC (measured from release) and
    // across SLOT_LOW/SLOT_REL (measured from slot start), so it is only
    // cleared where a new time reference begins.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        pres_sample = 1'b0;
        bit_sample  = 1'b0;
        slot_end    = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (accept) begin
                    state_d = (i_cmd == CMD_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
                end
            end
            ST_RST_LOW: begin
                if (tick && us_cnt_q == RSTL_LAST) begin
                    state_d = ST_RST_PDS;
                    cnt_clr = 1'b1;
                end
            end
            ST_RST_PDS: begin
                if (tick && us_cnt_q == PDS_LAST) begin
                    pres_sample = 1'b1;
                    state_d     = ST_RST_REC;
                end
            end
            ST_RST_REC: begin
                if (tick && us_cnt_q == RSTL_LAST) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            ST_SLOT_LOW: begin
                if (tick && us_cnt_q == low_last) begin
                    if (write_zero) begin
                        state_d = ST_SLOT_REC;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_SLOT_REL;
                    end
                end
            end
            ST_SLOT_REL: begin
                if (tick && us_cnt_q == RS_LAST && is_read) begin
                    bit_sample = 1'b1;
                end
                if (tick && us_cnt_q == SLOT_LAST) begin
                    state_d = ST_SLOT_REC;
                    cnt_clr = 1'b1;
                end
            end
            ST_SLOT_REC: begin
                if (tick && us_cnt_q == REC_LAST) begin
                    slot_end = 1'b1;
                    cnt_clr  = 1'b1;
                    if (!last_bit) begin
                        state_d = ST_SLOT_LOW;
                    end else if (cmd_q == CMD_WRITE && spu_q) begin
                        state_d = ST_SPU;
                    end else begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end
            end
            ST_SPU: begin
                cnt_clr = 1'b1;
                if (i_spu_release) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Microsecond counter for the current timing reference.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            us_cnt_q <= '0;
        end else if (tick) begin
            us_cnt_q <= us_cnt_q + 1'b1;
        end
    end

    // Bus drivers are registered from the next state so the line changes
    // on the same edge as the state, starting the cycle after accept.
    // Strong pull-up is only ever on in SPU, where the line is released.
    assign drive_low_d = (state_d == ST_RST_LOW) || (state_d == ST_SLOT_LOW);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ow_q        <= 1'b1;
            strong_pu_q <= 1'b0;
        end else begin
            ow_q        <= !drive_low_d;
            strong_pu_q <= (state_d == ST_SPU);
        end
    end

    // Command capture, bit serialisation and result publication. Results
    // are published only at completion so they stay stable between
    // completions of the same command type.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q      <= CMD_RESET;
            data_q     <= '0;
            spu_q      <= 1'b0;
            bit_cnt_q  <= '0;
            pres_q     <= 1'b0;
            rsp_q      <= 1'b0;
            rdata_q    <= '0;
            presence_q <= 1'b0;
        end else begin
            rsp_q <= done;
            if (accept) begin
                cmd_q     <= cmd_t'(i_cmd);
                data_q    <= i_wdata;
                spu_q     <= i_spu;
                bit_cnt_q <= '0;
            end else begin
                // Reads shift in at the top so that after eight LSB-first
                // bits the byte sits in natural order.
                if (bit_sample) begin
                    data_q <= {sync2_q, data_q[7:1]};
                end
                if (slot_end) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (cmd_q == CMD_WRITE) begin
                        data_q <= {1'b0, data_q[7:1]};
                    end
                end
            end
            if (pres_sample) begin
                pres_q <= !sync2_q;
            end
            if (done) begin
                case (cmd_q)
                    CMD_RESET:    presence_q <= pres_q;
                    CMD_READ:     rdata_q    <= data_q;
                    CMD_READ_BIT: rdata_q    <= {7'd0, data_q[7]};
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master at a 1 MHz clock (one clock per microsecond).
// A behavioural slave answers resets and read slots on an open-drain bus;
// a response scoreboard and a low-pulse scoreboard are fed by the driver
// and drained by independent monitors.
module tb_onewire_master;

    localparam int T_RSTL = 480;
    localparam int T_SLOT = 60;
    localparam int T_LOW1 = 6;
    localparam int T_REC  = 10;
    localparam int SLOT_PERIOD = T_SLOT + T_REC;
    localparam logic [15:0] NO_CHECK = 16'hFFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic [1:0] i_cmd = 2'd0;
    logic [7:0] i_wdata = 8'd0;
    logic       i_spu = 1'b0;
    logic       i_spu_release = 1'b0;
    logic       o_cmd_ready;
    logic       o_rsp_valid;
    logic [7:0] o_rdata;
    logic       o_presence;
    logic       o_busy;
    logic       O_ONE_WIRE;
    logic       O_STRONG_PU;
    logic [2:0] o_dbg_state;
    logic       slave_low = 1'b0;
    logic       one_wire_in;

    // Open-drain bus: low if either side pulls it down.
    assign one_wire_in = O_ONE_WIRE & ~slave_low;

    onewire_master #(
        .CLK_HZ (1_000_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd         (i_cmd),
        .i_wdata       (i_wdata),
        .i_spu         (i_spu),
        .i_spu_release (i_spu_release),
        .o_rsp_valid   (o_rsp_valid),
        .o_rdata       (o_rdata),
        .o_presence    (o_presence),
        .o_busy        (o_busy),
        .I_ONE_WIRE    (one_wire_in),
        .O_ONE_WIRE    (O_ONE_WIRE),
        .O_STRONG_PU   (O_STRONG_PU),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;
    // {latency[15:0], presence, rdata[7:0]}
    logic [24:0] exp_q[$];
    // {width[15:0], gap from previous pulse start[15:0]}
    logic [31:0] pulse_q[$];
    logic        rd_q[$];
    logic        slave_present = 1'b0;
    logic        ign_pulse = 1'b0;
    logic [7:0]  model_rdata = 8'd0;
    logic        model_pres = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave ----------------
    initial begin : slave
        logic b;
        int   t0;
        forever begin
            @(negedge O_ONE_WIRE);
            t0 = cyc;
            if (rd_q.size() > 0) begin
                b = rd_q.pop_front();
                if (!b) begin
                    slave_low = 1'b1;
                    repeat ($urandom_range(25, 30)) @(posedge clk);
                    slave_low = 1'b0;
                end
            end else begin
                @(posedge O_ONE_WIRE);
                if ((cyc - t0) >= 400 && slave_present) begin
                    repeat ($urandom_range(15, 50)) @(posedge clk);
                    slave_low = 1'b1;
                    repeat ($urandom_range(100, 200)) @(posedge clk);
                    slave_low = 1'b0;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    // Response monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin : rsp_mon
        logic [24:0] e;
        if (rst && o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 32'(o_rdata), 32'(e[7:0]));
                chk("rsp_presence", 32'(o_presence), 32'(e[8]));
                if (e[24:9] != NO_CHECK) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e[24:9]));
                chk("rsp_ready", 32'(o_cmd_ready), 32'd1);
            end
        end
    end

    // Low-pulse monitor: measures every master low pulse and slot spacing.
    logic ow_prev = 1'b1;
    int   low_start = 0;
    int   low_len = 0;
    int   prev_start = 0;
    always @(negedge clk) begin : pulse_mon
        logic [31:0] p;
        if (!O_ONE_WIRE && ow_prev) begin
            low_start = cyc;
            low_len   = 0;
        end
        if (!O_ONE_WIRE) low_len++;
        if (O_ONE_WIRE && !ow_prev) begin
            if (!ign_pulse) begin
                if (pulse_q.size() == 0) begin
                    chk("pulse_unexpected", 32'd1, 32'd0);
                end else begin
                    p = pulse_q.pop_front();
                    chk("pulse_width", 32'(low_len), 32'(p[31:16]));
                    if (p[15:0] != NO_CHECK) chk("slot_period", 32'(low_start - prev_start), 32'(p[15:0]));
                end
            end
            prev_start = low_start;
        end
        ow_prev = O_ONE_WIRE;
    end

    // Strong pull-up and active pull-down must never overlap.
    always @(negedge clk) begin
        if (rst && cyc > 2) chk("spu_exclusive", 32'(O_STRONG_PU & ~O_ONE_WIRE), 32'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!o_cmd_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", 32'(o_cmd_ready), 32'd1);
    endtask

    // sd: slave presence (bit 0) for reset, slave data for reads.
    task automatic send(input logic [1:0] cmd, input logic [7:0] wd, input logic spu,
                        input logic [7:0] sd, input logic track);
        logic [15:0] lat;
        logic [15:0] w;
        wait_idle();
        if (track) begin
            lat = NO_CHECK;
            case (cmd)
                2'd0: begin
                    slave_present = sd[0];
                    model_pres = sd[0];
                    pulse_q.push_back({16'(T_RSTL), NO_CHECK});
                    lat = 16'(2 * T_RSTL);
                end
                2'd1: begin
                    for (int i = 0; i < 8; i++) begin
                        w = wd[i] ? 16'(T_LOW1) : 16'(T_SLOT);
                        pulse_q.push_back({w, (i == 0) ? NO_CHECK : 16'(SLOT_PERIOD)});
                    end
                    lat = spu ? NO_CHECK : 16'(8 * SLOT_PERIOD);
                end
                2'd2: begin
                    model_rdata = sd;
                    for (int i = 0; i < 8; i++) begin
                        pulse_q.push_back({16'(T_LOW1), (i == 0) ? NO_CHECK : 16'(SLOT_PERIOD)});
                        rd_q.push_back(sd[i]);
                    end
                    lat = 16'(8 * SLOT_PERIOD);
                end
                default: begin
                    model_rdata = {7'd0, sd[0]};
                    pulse_q.push_back({16'(T_LOW1), NO_CHECK});
                    rd_q.push_back(sd[0]);
                    lat = 16'(SLOT_PERIOD);
                end
            endcase
            exp_q.push_back({lat, model_pres, model_rdata});
        end
        i_cmd_valid = 1'b1;
        i_cmd       = cmd;
        i_wdata     = wd;
        i_spu       = spu;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        i_cmd_valid = 1'b0;
        i_cmd       = 2'($urandom);
        i_wdata     = 8'($urandom);
        i_spu       = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int g;
        logic [1:0] k;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("rst_ow", 32'(O_ONE_WIRE), 32'd1);
        chk("rst_spu", 32'(O_STRONG_PU), 32'd0);
        chk("rst_rsp", 32'(o_rsp_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_presence", 32'(o_presence), 32'd0);

        // Bus reset with and without a device answering.
        send(2'd0, 8'd0, 1'b0, 8'd1, 1'b1);
        send(2'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        send(2'd0, 8'd0, 1'b0, 8'd1, 1'b1);

        // Skip ROM byte and a scratchpad-style read.
        send(2'd1, 8'hCC, 1'b0, 8'd0, 1'b1);
        send(2'd2, 8'd0, 1'b0, 8'h50, 1'b1);

        // Convert T with strong pull-up.
        send(2'd1, 8'h44, 1'b1, 8'd0, 1'b1);
        g = 0;
        @(negedge clk);
        while (!O_STRONG_PU && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("spu_enter", 32'(O_STRONG_PU), 32'd1);
        chk("spu_latency", 32'(cyc - acc_cyc), 32'(8 * SLOT_PERIOD));
        chk("spu_bus_released", 32'(O_ONE_WIRE), 32'd1);
        repeat ($urandom_range(20, 80)) @(negedge clk);
        chk("spu_hold", 32'(O_STRONG_PU), 32'd1);
        chk("spu_busy", 32'(o_busy), 32'd1);
        chk("spu_no_early_rsp", 32'(exp_q.size()), 32'd1);
        i_spu_release = 1'b1;
        @(negedge clk);
        i_spu_release = 1'b0;
        chk("spu_exit", 32'(O_STRONG_PU), 32'd0);

        // Conversion-done polling: device holds low, then releases.
        send(2'd3, 8'd0, 1'b0, 8'h00, 1'b1);
        send(2'd3, 8'd0, 1'b0, 8'h01, 1'b1);

        // Reset asserted in the middle of a write byte.
        send(2'd1, 8'hA5, 1'b0, 8'd0, 1'b0);
        ign_pulse = 1'b1;
        repeat ($urandom_range(100, 300)) @(negedge clk);
        g = 0;
        while (O_ONE_WIRE && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("abort_line_low", 32'(O_ONE_WIRE), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_release", 32'(O_ONE_WIRE), 32'd1);
        chk("abort_idle", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(o_cmd_ready), 32'd1);
        chk("abort_presence", 32'(o_presence), 32'd0);
        chk("abort_rdata", 32'(o_rdata), 32'd0);
        model_pres  = 1'b0;
        model_rdata = 8'd0;
        repeat (5) @(negedge clk);
        ign_pulse = 1'b0;

        // Randomised command mix.
        for (int n = 0; n < 10; n++) begin
            k = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            case (k)
                2'd0:    send(2'd0, 8'd0, 1'b0, {7'd0, d[0]}, 1'b1);
                2'd1:    send(2'd1, d, 1'b0, 8'd0, 1'b1);
                2'd2:    send(2'd2, 8'($urandom), 1'b0, d, 1'b1);
                default: send(2'd3, 8'd0, 1'b0, d, 1'b1);
            endcase
        end

        wait_idle();
        repeat (10) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("pulse_drain", 32'(pulse_q.size()), 32'd0);
        chk("slave_drain", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #800_000;
        errors++;
        $display("FAIL watchdog: actual timeout required completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
